proc_ctrl_unit: RTL and testbench

Parametrised control unit for the simple register-file processor. It accepts one instruction per Run request and sequences the register-file, A/G and DIN bus enables through 2 or 4 timesteps. It signals completion with a one-cycle Done pulse. Compared with the previous generation it adds register-count scaling, an AND operation, a conditional move (mvnz), illegal-opcode flagging, an explicit ALU op select and back-to-back instruction issue.

---
 rtl/proc_pkg.sv | 43 ++++
 rtl/onehot_dec.sv | 19 +
 rtl/proc_ctrl_unit.sv | 164 ++++++++++++++++
 tb/tb_proc_ctrl_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the register-file processor control unit.
// Contents:
//   - opcode constants carried in IR[IR_W-1 -: 3]
//   - ALU operation select encodings driven on alu_op
//   - control FSM state type
//   - helpers classifying opcodes
package proc_pkg;

  localparam logic [2:0] OPC_MV   = 3'd0;
  localparam logic [2:0] OPC_MVI  = 3'd1;
  localparam logic [2:0] OPC_ADD  = 3'd2;
  localparam logic [2:0] OPC_SUB  = 3'd3;
  localparam logic [2:0] OPC_AND  = 3'd4;
  localparam logic [2:0] OPC_MVNZ = 3'd5;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_AND = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_t;

  // True for the three-step opcodes that go through A and G.
  function automatic logic is_alu_opc(input logic [2:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND);
  endfunction

  // ALU select for an ALU opcode; add for anything else.
  function automatic logic [1:0] alu_sel(input logic [2:0] opc);
    logic [1:0] sel;
    case (opc)
      OPC_SUB: sel = ALU_OP_SUB;
      OPC_AND: sel = ALU_OP_AND;
      default: sel = ALU_OP_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with enable.
// Ports:
//   i_idx  in  W       register index
//   i_en   in  1       decode enable; output is all-zero when low
//   o_vec  out 2**W    one-hot vector with bit i_idx set when enabled
module onehot_dec #(
  parameter int W = 3
) (
  input  logic [W-1:0]      i_idx,
  input  logic              i_en,
  output logic [(2**W)-1:0] o_vec
);

  always_comb begin
    o_vec = '0;
    if (i_en) o_vec[i_idx] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_unit.sv
// Control unit for the simple register-file processor. Accepts one
// instruction per Run request in IDLE and sequences the bus/load enables
// over one (mv, mvi, mvnz, illegal) or three (add, sub, and) timesteps.
// Ports:
//   clk      in   1      rising-edge clock
//   Resetn   in   1      asynchronous active-low reset
//   Run      in   1      start request, sampled only in IDLE
//   IR       in   IR_W   instruction {opc[2:0], rx, ry}
//   Gnz      in   1      G non-zero status for mvnz
//   IRin     out  1      IR load enable (mirrors Run in IDLE)
//   Rin      out  NREGS  one-hot register write enables
//   Rout     out  NREGS  one-hot register bus-drive enables
//   Ain      out  1      A load
//   Gin      out  1      G load
//   Gout     out  1      G drives bus
//   DINout   out  1      DIN drives bus
//   alu_op   out  2      ALU select, 00 unless Gin
//   Done     out  1      completion pulse
//   Illegal  out  1      undefined-opcode pulse, coincident with Done
module proc_ctrl_unit
  import proc_pkg::*;
#(
  parameter  int RA_W  = 3,
  localparam int NREGS = 2**RA_W,
  localparam int IR_W  = 3 + 2*RA_W
) (
  input  logic             clk,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [IR_W-1:0]  IR,
  input  logic             Gnz,
  output logic             IRin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             Ain,
  output logic             Gin,
  output logic             Gout,
  output logic             DINout,
  output logic [1:0]       alu_op,
  output logic             Done,
  output logic             Illegal
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IR_W-1:0] r_ir;
  logic            w_ir_load;

  logic [2:0]      w_opc;
  logic [RA_W-1:0] w_rx;
  logic [RA_W-1:0] w_ry;

  // Register select requests from the sequencer.
  logic            w_rx_rin;
  logic            w_rx_rout;
  logic            w_ry_rout;
  logic [NREGS-1:0] w_rx_oh;
  logic [NREGS-1:0] w_ry_oh;

  assign w_opc = r_ir[IR_W-1 -: 3];
  assign w_rx  = r_ir[2*RA_W-1 -: RA_W];
  assign w_ry  = r_ir[RA_W-1:0];

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_load) r_ir <= IR;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_rx_rin    = 1'b0;
    w_rx_rout   = 1'b0;
    w_ry_rout   = 1'b0;
    IRin        = 1'b0;
    Ain         = 1'b0;
    Gin         = 1'b0;
    Gout        = 1'b0;
    DINout      = 1'b0;
    alu_op      = ALU_OP_ADD;
    Done        = 1'b0;
    Illegal     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Gated by Resetn so every output is low while reset is held,
        // even though Run is passed straight through in IDLE.
        IRin = Run & Resetn;
        if (Run) begin
          w_ir_load   = 1'b1;
          w_state_nxt = ST_T1;
        end
      end

      ST_T1: begin
        w_state_nxt = ST_IDLE;
        case (w_opc)
          OPC_MV: begin
            w_ry_rout = 1'b1;
            w_rx_rin  = 1'b1;
            Done      = 1'b1;
          end
          OPC_MVI: begin
            DINout   = 1'b1;
            w_rx_rin = 1'b1;
            Done     = 1'b1;
          end
          OPC_MVNZ: begin
            w_ry_rout = Gnz;
            w_rx_rin  = Gnz;
            Done      = 1'b1;
          end
          OPC_ADD, OPC_SUB, OPC_AND: begin
            w_rx_rout   = 1'b1;
            Ain         = 1'b1;
            w_state_nxt = ST_T2;
          end
          default: begin
            Illegal = 1'b1;
            Done    = 1'b1;
          end
        endcase
      end

      ST_T2: begin
        w_ry_rout   = 1'b1;
        Gin         = 1'b1;
        alu_op      = alu_sel(w_opc);
        w_state_nxt = is_alu_opc(w_opc) ? ST_T3 : ST_IDLE;
      end

      ST_T3: begin
        Gout        = 1'b1;
        w_rx_rin    = 1'b1;
        Done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  onehot_dec #(.W(RA_W)) u_dec_rx (
    .i_idx (w_rx),
    .i_en  (w_rx_rin | w_rx_rout),
    .o_vec (w_rx_oh)
  );

  onehot_dec #(.W(RA_W)) u_dec_ry (
    .i_idx (w_ry),
    .i_en  (w_ry_rout),
    .o_vec (w_ry_oh)
  );

  // rx is only ever a write target or a bus source, never both in one step.
  assign Rin  = w_rx_rin ? w_rx_oh : '0;
  assign Rout = (w_rx_rout ? w_rx_oh : '0) | w_ry_oh;

endmodule

// File: tb/tb_proc_ctrl_unit.sv
module tb_proc_ctrl_unit;

  logic        clk;
  logic        Resetn;
  logic        Run;
  logic [8:0]  IR;
  logic        Gnz;
  logic        IRin, Ain, Gin, Gout, DINout, Done, Illegal;
  logic [7:0]  Rin, Rout;
  logic [1:0]  alu_op;

  logic        Run4;
  logic [10:0] IR4;
  logic        IRin4, Ain4, Gin4, Gout4, DINout4, Done4, Illegal4;
  logic [15:0] Rin4, Rout4;
  logic [1:0]  alu_op4;

  int n_chk = 0;
  int n_err = 0;

  proc_ctrl_unit #(.RA_W(3)) dut (
    .clk(clk), .Resetn(Resetn), .Run(Run), .IR(IR), .Gnz(Gnz),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .DINout(DINout), .alu_op(alu_op), .Done(Done),
    .Illegal(Illegal)
  );

  proc_ctrl_unit #(.RA_W(4)) dut4 (
    .clk(clk), .Resetn(Resetn), .Run(Run4), .IR(IR4), .Gnz(1'b0),
    .IRin(IRin4), .Rin(Rin4), .Rout(Rout4), .Ain(Ain4), .Gin(Gin4),
    .Gout(Gout4), .DINout(DINout4), .alu_op(alu_op4), .Done(Done4),
    .Illegal(Illegal4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for one cycle of an accepted instruction.
  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain, gin, gout, dinout;
    logic [1:0] alu;
    logic       done, illegal;
    logic       gnz_dep;
  } exp_t;

  exp_t q[$];

  // Build the cycle-by-cycle expectation of an instruction from its opcode.
  task automatic push_instr(input logic [8:0] ir);
    logic [2:0] opc;
    int rx, ry;
    exp_t r;
    opc = ir[8:6];
    rx  = int'(ir[5:3]);
    ry  = int'(ir[2:0]);
    r = '0;
    case (opc)
      3'd0: begin r.rin = 8'(1) << rx; r.rout = 8'(1) << ry; r.done = 1; q.push_back(r); end
      3'd1: begin r.rin = 8'(1) << rx; r.dinout = 1; r.done = 1; q.push_back(r); end
      3'd5: begin r.rin = 8'(1) << rx; r.rout = 8'(1) << ry; r.done = 1; r.gnz_dep = 1; q.push_back(r); end
      3'd2, 3'd3, 3'd4: begin
        r.rout = 8'(1) << rx; r.ain = 1; q.push_back(r);
        r = '0; r.rout = 8'(1) << ry; r.gin = 1; r.alu = 2'(opc - 3'd2); q.push_back(r);
        r = '0; r.rin = 8'(1) << rx; r.gout = 1; r.done = 1; q.push_back(r);
      end
      default: begin r.illegal = 1; r.done = 1; q.push_back(r); end
    endcase
  endtask

  task automatic drive(input logic run, input logic [8:0] ir, input logic gnz);
    Run = run; IR = ir; Gnz = gnz;
    #2;
  endtask

  // Called just after a falling edge; checks the cycle against the model
  // and returns just after the next falling edge.
  task automatic step(input logic run, input logic [8:0] ir, input logic gnz);
    exp_t e;
    Run = run; IR = ir; Gnz = gnz;
    #2;
    if (!Resetn) begin
      e = '0;
      q.delete();
    end else if (q.size() == 0) begin
      e = '0;
      e.irin = run;
    end else begin
      e = q[0];
      if (e.gnz_dep && !gnz) begin e.rin = '0; e.rout = '0; end
    end
    chk("irin", 32'(IRin), 32'(e.irin));
    chk("rin", 32'(Rin), 32'(e.rin));
    chk("rout", 32'(Rout), 32'(e.rout));
    chk("ain", 32'(Ain), 32'(e.ain));
    chk("gin", 32'(Gin), 32'(e.gin));
    chk("gout", 32'(Gout), 32'(e.gout));
    chk("dinout", 32'(DINout), 32'(e.dinout));
    chk("alu_op", 32'(alu_op), 32'(e.alu));
    chk("done", 32'(Done), 32'(e.done));
    chk("illegal", 32'(Illegal), 32'(e.illegal));
    chk("one_bus_driver", 32'(($countones(Rout) + int'(Gout) + int'(DINout)) <= 1), 32'd1);
    chk("rin_onehot0", 32'($onehot0(Rin)), 32'd1);
    @(posedge clk);
    if (Resetn) begin
      if (q.size() == 0) begin
        if (run) push_instr(ir);
      end else begin
        void'(q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  initial begin
    Resetn = 1'b0; Run = 1'b1; IR = '0; Gnz = 1'b0;
    Run4 = 1'b0; IR4 = '0;
    @(negedge clk);

    // Reset held with Run=1: everything stays low.
    for (int i = 0; i < 3; i++) step(1'b1, 9'h1ff, 1'b1);
    chk("reset_irin4", 32'(IRin4), 32'd0);
    Resetn = 1'b1;

    drive(1'b1, 9'b000_011_101, 1'b0);
    chk("idle_irin", 32'(IRin), 32'd1);
    step(1'b1, 9'b000_011_101, 1'b0);
    drive(1'b0, 9'h000, 1'b0);
    chk("mv_rin", 32'(Rin), 32'h08);
    chk("mv_rout", 32'(Rout), 32'h20);
    chk("mv_done", 32'(Done), 32'd1);
    step(1'b0, 9'h000, 1'b0);
    step(1'b0, 9'h000, 1'b0);

    // ALU ops: add R1,R2 / sub / and
    for (int k = 0; k < 3; k++) begin
      logic [8:0] ir;
      ir = {3'(2 + k), 3'd1, 3'd2};
      step(1'b1, ir, 1'b0);
      drive(1'b0, 9'h1ff, 1'b0);
      chk("alu_t1_ain", 32'(Ain), 32'd1);
      chk("alu_t1_rout", 32'(Rout), 32'h02);
      step(1'b0, 9'h1ff, 1'b0);
      drive(1'b1, 9'h1ff, 1'b0);
      chk("alu_t2_gin", 32'(Gin), 32'd1);
      chk("alu_t2_rout", 32'(Rout), 32'h04);
      chk("alu_t2_op", 32'(alu_op), 32'(k));
      step(1'b1, 9'h1ff, 1'b0);
      drive(1'b0, 9'h000, 1'b0);
      chk("alu_t3_gout", 32'(Gout), 32'd1);
      chk("alu_t3_rin", 32'(Rin), 32'h02);
      chk("alu_t3_done", 32'(Done), 32'd1);
      step(1'b0, 9'h000, 1'b0);
    end

    // mvnz R4,R0 with Gnz low then high
    step(1'b1, 9'b101_100_000, 1'b1);
    drive(1'b0, 9'h000, 1'b0);
    chk("mvnz0_rin", 32'(Rin), 32'd0);
    chk("mvnz0_rout", 32'(Rout), 32'd0);
    chk("mvnz0_done", 32'(Done), 32'd1);
    step(1'b0, 9'h000, 1'b0);
    step(1'b1, 9'b101_100_000, 1'b0);
    drive(1'b0, 9'h000, 1'b1);
    chk("mvnz1_rin", 32'(Rin), 32'h10);
    chk("mvnz1_rout", 32'(Rout), 32'h01);
    chk("mvnz1_done", 32'(Done), 32'd1);
    step(1'b0, 9'h000, 1'b1);

    // Illegal opcode, then back-to-back mvi R7
    step(1'b1, 9'b110_000_000, 1'b0);
    drive(1'b0, 9'h000, 1'b0);
    chk("ill_illegal", 32'(Illegal), 32'd1);
    chk("ill_done", 32'(Done), 32'd1);
    chk("ill_rinrout", 32'({Rin, Rout}), 32'd0);
    step(1'b0, 9'h000, 1'b0);
    drive(1'b1, 9'b001_111_000, 1'b0);
    chk("b2b_irin", 32'(IRin), 32'd1);
    step(1'b1, 9'b001_111_000, 1'b0);
    drive(1'b0, 9'h000, 1'b0);
    chk("mvi_dinout", 32'(DINout), 32'd1);
    chk("mvi_rin", 32'(Rin), 32'h80);
    chk("mvi_done", 32'(Done), 32'd1);
    step(1'b0, 9'h000, 1'b0);

    // Reset during T2 of sub
    step(1'b1, 9'b011_010_110, 1'b0);
    step(1'b0, 9'h000, 1'b0);
    drive(1'b0, 9'h000, 1'b0);
    chk("sub_t2_gin", 32'(Gin), 32'd1);
    Resetn = 1'b0;
    #1;
    chk("rst_mid_gin", 32'(Gin), 32'd0);
    chk("rst_mid_rout", 32'(Rout), 32'd0);
    chk("rst_mid_done", 32'(Done), 32'd0);
    step(1'b1, 9'h000, 1'b0);
    Resetn = 1'b1;
    step(1'b0, 9'h000, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 9'h000, 1'b0);

    // RA_W=4 build: mv R15,R0
    Run4 = 1'b1; IR4 = 11'b000_1111_0000;
    @(posedge clk);
    @(negedge clk);
    Run4 = 1'b0; IR4 = '0;
    #2;
    chk("w4_rin", 32'(Rin4), 32'h8000);
    chk("w4_rout", 32'(Rout4), 32'h0001);
    chk("w4_done", 32'(Done4), 32'd1);
    @(negedge clk);
    #2;
    chk("w4_idle_done", 32'(Done4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
